// File: rtl/mult_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module : mult_sequencer_pkg
// Brief  : State encoding, strobe bit indices and sizing helper shared by the
//          multiplier sequencer, its datapath and its testbench.
// Rev    : 1.0  initial release
// ============================================================================
package mult_sequencer_pkg;

    localparam int c_STATE_W = 3;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_TEST  = 3'd2,
        ST_ADD   = 3'd3,
        ST_SHIFT = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int c_STB_LOAD  = 0;
    localparam int c_STB_ADD   = 1;
    localparam int c_STB_SUB   = 2;
    localparam int c_STB_SHIFT = 3;
    localparam int c_NUM_STB   = 4;

    // Width of a counter that must reach width-1; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : mult_sequencer_pkg
`default_nettype wire

// File: rtl/mult_sequencer_bit_counter.sv
`default_nettype none
// ============================================================================
// Module : bit_counter
// Brief  : Iteration counter for the multiplier sequencer; saturates at
//          WIDTH-1 and flags the last iteration.
// Rev    : 1.0  initial release
// ============================================================================
module bit_counter
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Saturating increment keeps the count inside 0..WIDTH-1 even if inc
    // were held on the last iteration.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != c_LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign last = (cnt_q == c_LAST);

endmodule : bit_counter
`default_nettype wire

// File: rtl/mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module : mult_sequencer
// Brief  : Control FSM for a WIDTH-bit shift-and-add multiplier datapath,
//          unsigned or two's-complement signed.
// Rev    : 1.0  initial release
// ============================================================================
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic mode,
    input  logic abort,
    input  logic mplr_lsb,
    output logic load,
    output logic add_en,
    output logic sub_en,
    output logic shift_en,
    output logic busy,
    output logic done
);

    localparam int               c_CNT_W    = cnt_width(WIDTH);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);

    state_e               state_q;
    state_e               state_d;
    logic                 mode_q;
    logic                 mode_d;
    logic                 w_cnt_clr;
    logic                 w_cnt_inc;
    logic [c_CNT_W-1:0]   w_cnt;
    logic                 w_last;
    logic                 w_sub_bit;
    logic [c_NUM_STB-1:0] w_strobe;

    bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (c_CNT_W)
    ) u_bit_counter (
        .clock (clock),
        .reset (reset),
        .clr   (w_cnt_clr),
        .inc   (w_cnt_inc),
        .cnt   (w_cnt),
        .last  (w_last)
    );

    // The multiplier MSB carries negative weight in signed mode.
    assign w_sub_bit = mode_q && (w_cnt == c_LAST_CNT);

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        w_cnt_clr = 1'b0;
        w_cnt_inc = 1'b0;
        w_strobe  = '0;
        busy      = (state_q != ST_IDLE);
        done      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    mode_d  = mode;
                end
            end
            ST_LOAD: begin
                w_strobe[c_STB_LOAD] = 1'b1;
                w_cnt_clr            = 1'b1;
                state_d              = ST_TEST;
            end
            ST_TEST: begin
                state_d = mplr_lsb ? ST_ADD : ST_SHIFT;
            end
            ST_ADD: begin
                if (w_sub_bit) begin
                    w_strobe[c_STB_SUB] = 1'b1;
                end else begin
                    w_strobe[c_STB_ADD] = 1'b1;
                end
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_strobe[c_STB_SHIFT] = 1'b1;
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    w_cnt_inc = 1'b1;
                    state_d   = ST_TEST;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides every transition above, including a start in IDLE.
        if (abort) begin
            state_d   = ST_IDLE;
            mode_d    = mode_q;
            w_cnt_clr = 1'b1;
            w_cnt_inc = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
        end
    end

    assign load     = w_strobe[c_STB_LOAD];
    assign add_en   = w_strobe[c_STB_ADD];
    assign sub_en   = w_strobe[c_STB_SUB];
    assign shift_en = w_strobe[c_STB_SHIFT];

endmodule : mult_sequencer
`default_nettype wire

// File: tb/tb_mult_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_mult_sequencer
// Brief  : Directed self-checking bench for mult_sequencer with a behavioural
//          shift-and-add datapath driving mplr_lsb.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mult_sequencer;

    localparam int W = 4;

    logic clock = 1'b0;
    logic reset, start, mode, abort, mplr_lsb;
    logic load, add_en, sub_en, shift_en, busy, done;

    always #5 clock = ~clock;

    mult_sequencer #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .mode     (mode),
        .abort    (abort),
        .mplr_lsb (mplr_lsb),
        .load     (load),
        .add_en   (add_en),
        .sub_en   (sub_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done)
    );

    // Behavioural datapath: {acc, q_reg} is the double-width product register.
    logic [W-1:0] mcand_v   = '0;
    logic [W-1:0] mplr_v    = '0;
    logic         dp_signed = 1'b0;
    logic [W:0]   acc       = '0;
    logic [W-1:0] q_reg     = '0;
    logic [W:0]   m_ext;

    assign m_ext    = dp_signed ? {mcand_v[W-1], mcand_v} : {1'b0, mcand_v};
    assign mplr_lsb = q_reg[0];

    always @(posedge clock) begin
        if (load) begin
            acc   <= '0;
            q_reg <= mplr_v;
        end else if (add_en) begin
            acc <= acc + m_ext;
        end else if (sub_en) begin
            acc <= acc - m_ext;
        end else if (shift_en) begin
            {acc, q_reg} <= {(dp_signed ? acc[W] : 1'b0), acc, q_reg[W-1:1]};
        end
    end

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vec = 0;
    int err = 0;
    int n_load = 0, n_add = 0, n_sub = 0, n_shift = 0, n_done = 0;
    int n_addcyc = 0, sub_at_add = 0, load_cyc = 0, done_cyc = 0;

    // Advance one cycle, sample on the falling edge, tally strobes and
    // check that the datapath strobes are mutually exclusive.
    task automatic tick();
        @(negedge clock);
        if (load) begin n_load++; load_cyc = cyc; end
        if (add_en) n_add++;
        if (sub_en) n_sub++;
        if (shift_en) n_shift++;
        if (add_en || sub_en) begin
            n_addcyc++;
            if (sub_en) sub_at_add = n_addcyc;
        end
        if (done) begin n_done++; done_cyc = cyc; end
        vec++;
        if ((int'(load) + int'(add_en) + int'(sub_en) + int'(shift_en)) > 1) begin
            err++;
            $display("FAIL onehot @cyc %0d: strobes {load,add,sub,shift}=%b, required at most one high",
                     cyc, {load, add_en, sub_en, shift_en});
        end
    endtask

    task automatic start_op(input logic [W-1:0] mc, input logic [W-1:0] mp, input logic md);
        mcand_v   = mc;
        mplr_v    = mp;
        dp_signed = md;
        mode      = md;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n0;
        int i;
        n0 = n_done;
        i  = 0;
        while (n_done == n0 && i < 200) begin
            tick();
            i++;
        end
        vec++;
        if (n_done == n0) begin
            err++;
            $display("FAIL %s_timeout: no done pulse within 200 cycles", name);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        vec++;
        if ({load, add_en, sub_en, shift_en, done} !== 5'b0) begin
            err++;
            $display("FAIL reset_strobes: got %b, required 00000", {load, add_en, sub_en, shift_en, done});
        end
        vec++;
        if (busy !== 1'b0) begin
            err++;
            $display("FAIL reset_busy: got %b, required 0", busy);
        end
        reset = 1'b0;
        tick();
        vec++;
        if (busy !== 1'b0) begin
            err++;
            $display("FAIL idle_busy: got %b, required 0", busy);
        end
    endtask

    task automatic test_zero_mplr();
        int a0, s0, sh0;
        a0 = n_add; s0 = n_sub; sh0 = n_shift;
        start_op(4'h5, 4'h0, 1'b0);
        wait_done("zero");
        vec++;
        if (n_add - a0 !== 0 || n_sub - s0 !== 0) begin
            err++;
            $display("FAIL zero_adds: add=%0d sub=%0d, required 0 and 0", n_add - a0, n_sub - s0);
        end
        vec++;
        if (n_shift - sh0 !== 4) begin
            err++;
            $display("FAIL zero_shifts: got %0d, required 4", n_shift - sh0);
        end
        vec++;
        if (done_cyc - load_cyc !== 9) begin
            err++;
            $display("FAIL zero_latency: load->done %0d cycles, required 9", done_cyc - load_cyc);
        end
        vec++;
        if ({acc[W-1:0], q_reg} !== 8'h00) begin
            err++;
            $display("FAIL zero_product: got %h, required 00", {acc[W-1:0], q_reg});
        end
        tick();
        vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            err++;
            $display("FAIL zero_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_all_ones();
        int a0, s0, sh0;
        a0 = n_add; s0 = n_sub; sh0 = n_shift;
        start_op(4'hF, 4'hF, 1'b0);
        wait_done("ones");
        vec++;
        if (n_add - a0 !== 4 || n_shift - sh0 !== 4) begin
            err++;
            $display("FAIL ones_counts: add=%0d shift=%0d, required 4 and 4", n_add - a0, n_shift - sh0);
        end
        vec++;
        if (n_sub - s0 !== 0) begin
            err++;
            $display("FAIL ones_sub: got %0d, required 0", n_sub - s0);
        end
        vec++;
        if (done_cyc - load_cyc !== 13) begin
            err++;
            $display("FAIL ones_latency: load->done %0d cycles, required 13", done_cyc - load_cyc);
        end
        vec++;
        if ({acc[W-1:0], q_reg} !== 8'hE1) begin
            err++;
            $display("FAIL ones_product: got %h, required e1", {acc[W-1:0], q_reg});
        end
        tick();
    endtask

    task automatic test_signed();
        int a0, s0, c0;
        a0 = n_add; s0 = n_sub; c0 = n_addcyc;
        start_op(4'h3, 4'hB, 1'b1);
        wait_done("signed");
        vec++;
        if (n_sub - s0 !== 1 || n_add - a0 !== 2) begin
            err++;
            $display("FAIL signed_counts: sub=%0d add=%0d, required 1 and 2", n_sub - s0, n_add - a0);
        end
        vec++;
        if (sub_at_add - c0 !== 3) begin
            err++;
            $display("FAIL signed_sub_pos: sub in add-cycle %0d, required 3 (last ADD)", sub_at_add - c0);
        end
        vec++;
        if (done_cyc - load_cyc !== 12) begin
            err++;
            $display("FAIL signed_latency: load->done %0d cycles, required 12", done_cyc - load_cyc);
        end
        vec++;
        if ({acc[W-1:0], q_reg} !== 8'hF1) begin
            err++;
            $display("FAIL signed_product: got %h, required f1", {acc[W-1:0], q_reg});
        end
        tick();
    endtask

    task automatic test_reset_mid_shift();
        int i;
        start_op(4'h3, 4'h0, 1'b0);
        i = 0;
        while (shift_en !== 1'b1 && i < 20) begin
            tick();
            i++;
        end
        vec++;
        if (shift_en !== 1'b1) begin
            err++;
            $display("FAIL midreset_reach: shift_en=%b, required 1 within 20 cycles", shift_en);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vec++;
        if ({load, add_en, sub_en, shift_en, done, busy} !== 6'b0) begin
            err++;
            $display("FAIL midreset_outputs: got %b, required 000000",
                     {load, add_en, sub_en, shift_en, done, busy});
        end
        start_op(4'h3, 4'h5, 1'b0);
        wait_done("midreset");
        vec++;
        if (done_cyc - load_cyc !== 11) begin
            err++;
            $display("FAIL midreset_latency: load->done %0d cycles, required 11", done_cyc - load_cyc);
        end
        vec++;
        if ({acc[W-1:0], q_reg} !== 8'h0F) begin
            err++;
            $display("FAIL midreset_product: got %h, required 0f", {acc[W-1:0], q_reg});
        end
        tick();
    endtask

    task automatic test_abort();
        int ntest, i, d0, l0;
        start_op(4'h3, 4'h0, 1'b0);
        ntest = 0;
        i     = 0;
        while (ntest < 2 && i < 20) begin
            tick();
            if (busy && !load && !add_en && !sub_en && !shift_en && !done) ntest++;
            i++;
        end
        vec++;
        if (ntest !== 2) begin
            err++;
            $display("FAIL abort_reach: saw %0d TEST cycles, required 2", ntest);
        end
        d0    = n_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vec++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            err++;
            $display("FAIL abort_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        repeat (15) tick();
        vec++;
        if (n_done - d0 !== 0) begin
            err++;
            $display("FAIL abort_nodone: got %0d done pulses, required 0", n_done - d0);
        end
        l0    = n_load;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        vec++;
        if (busy !== 1'b0 || load !== 1'b0) begin
            err++;
            $display("FAIL abort_start: busy=%b load=%b, required 0 0", busy, load);
        end
        tick();
        tick();
        vec++;
        if (n_load - l0 !== 0) begin
            err++;
            $display("FAIL abort_start_load: got %0d loads, required 0", n_load - l0);
        end
    endtask

    task automatic test_back_to_back();
        int d0, l0, s0;
        d0 = n_done; l0 = n_load; s0 = n_sub;
        start_op(4'h7, 4'hE, 1'b0);
        repeat (3) tick();
        start = 1'b1;
        mode  = 1'b1;
        tick();
        start = 1'b0;
        wait_done("b2b");
        start = 1'b1;
        tick();
        start = 1'b0;
        mode  = 1'b0;
        vec++;
        if (busy !== 1'b0) begin
            err++;
            $display("FAIL b2b_done_start: busy=%b, required 0", busy);
        end
        repeat (6) tick();
        vec++;
        if (n_done - d0 !== 1 || n_load - l0 !== 1) begin
            err++;
            $display("FAIL b2b_counts: done=%0d load=%0d, required 1 and 1", n_done - d0, n_load - l0);
        end
        vec++;
        if (n_sub - s0 !== 0) begin
            err++;
            $display("FAIL b2b_mode_hold: got %0d sub pulses, required 0", n_sub - s0);
        end
        vec++;
        if (done_cyc - load_cyc !== 12) begin
            err++;
            $display("FAIL b2b_latency: load->done %0d cycles, required 12", done_cyc - load_cyc);
        end
        vec++;
        if ({acc[W-1:0], q_reg} !== 8'h62) begin
            err++;
            $display("FAIL b2b_product: got %h, required 62", {acc[W-1:0], q_reg});
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        abort = 1'b0;
        test_reset();
        test_zero_mplr();
        test_all_ones();
        test_signed();
        test_reset_mid_shift();
        test_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule : tb_mult_sequencer
`default_nettype wire
